// File: rtl/paramshift_pipe.sv
// paramshift_pipe: widens an operand (signed or unsigned), applies SLL/SRL/SRA/ROL
// by a runtime amount and passes the result through a STAGES-deep pipeline.
// The pipeline uses valid/ready handshaking and a single global stall.
module paramshift_pipe #(
    parameter int WIDTH    = 32,
    parameter int IN_WIDTH = 32,
    parameter int AMT_W    = 8,
    parameter int STAGES   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_WIDTH-1:0] in_data,
    input  logic                in_signed,
    input  logic [1:0]          in_mode,
    input  logic [AMT_W-1:0]    in_amt,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_data,
    output logic                out_ovf
);

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    // The amount is compared and reduced in a width that can always hold WIDTH,
    // even when AMT_W is too narrow to represent WIDTH itself.
    localparam int CW = (AMT_W > 32) ? AMT_W : 32;

    logic [WIDTH-1:0]   x_ext;
    logic [CW-1:0]      amt_w;
    logic [CW-1:0]      rot_amt;
    logic               amt_big;
    logic               fill_bit;
    logic [WIDTH-1:0]   sll_val;
    logic [WIDTH-1:0]   srl_val;
    logic [WIDTH-1:0]   sra_val;
    logic [WIDTH-1:0]   back_log;
    logic [WIDTH-1:0]   back_ari;
    logic [2*WIDTH-1:0] rol_wide;
    logic [WIDTH-1:0]   rol_val;
    logic [WIDTH-1:0]   res_next;
    logic               ovf_next;

    // Operand extension happens before any shift.
    generate
        if (IN_WIDTH == WIDTH) begin : gen_no_ext
            assign x_ext = in_data;
        end else begin : gen_ext
            logic sign_bit;
            assign sign_bit = in_signed & in_data[IN_WIDTH-1];
            assign x_ext    = {{(WIDTH-IN_WIDTH){sign_bit}}, in_data};
        end
    endgenerate

    assign amt_w    = CW'(in_amt);
    assign amt_big  = (amt_w >= CW'(WIDTH));
    assign rot_amt  = amt_w % CW'(WIDTH);
    assign fill_bit = in_signed & x_ext[WIDTH-1];

    // Raw shift candidates; each signed shift sits in its own statement so that
    // its signedness is not lost by mixing with unsigned operands.
    always_comb begin
        sll_val  = x_ext << amt_w;
        srl_val  = x_ext >> amt_w;
        sra_val  = $signed(x_ext) >>> amt_w;
        back_log = sll_val >> amt_w;
        back_ari = $signed(sll_val) >>> amt_w;
        // Rotating the doubled word and keeping the upper half works for any WIDTH.
        rol_wide = {x_ext, x_ext} << rot_amt;
        rol_val  = rol_wide[2*WIDTH-1:WIDTH];
    end

    // Mode selection, out-of-range amounts and the SLL overflow flag.
    always_comb begin
        res_next = '0;
        ovf_next = 1'b0;
        case (in_mode)
            MODE_SLL: begin
                if (amt_big) begin
                    res_next = '0;
                    ovf_next = (x_ext != '0);
                end else begin
                    res_next = sll_val;
                    ovf_next = in_signed ? (back_ari != x_ext) : (back_log != x_ext);
                end
            end
            MODE_SRL: begin
                res_next = amt_big ? '0 : srl_val;
            end
            MODE_SRA: begin
                if (amt_big) begin
                    res_next = {WIDTH{fill_bit}};
                end else begin
                    res_next = in_signed ? sra_val : srl_val;
                end
            end
            MODE_ROL: begin
                res_next = rol_val;
            end
            default: begin
                res_next = '0;
            end
        endcase
    end

    logic [STAGES-1:0]            valid_reg;
    logic [STAGES-1:0][WIDTH-1:0] data_reg;
    logic [STAGES-1:0]            ovf_reg;

    // Global stall: everything advances together whenever the last stage can drain.
    assign in_ready  = !valid_reg[STAGES-1] || out_ready;
    assign out_valid = valid_reg[STAGES-1];
    assign out_data  = data_reg[STAGES-1];
    assign out_ovf   = ovf_reg[STAGES-1];

    // Pipeline registers: stage 0 captures the computed result, later stages delay it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_reg <= '0;
            data_reg  <= '0;
            ovf_reg   <= '0;
        end else if (in_ready) begin
            valid_reg[0] <= in_valid;
            // Bubbles carry zeros so an empty stage never shows stale data.
            data_reg[0]  <= in_valid ? res_next : '0;
            ovf_reg[0]   <= in_valid & ovf_next;
            for (int i = 1; i < STAGES; i++) begin
                valid_reg[i] <= valid_reg[i-1];
                data_reg[i]  <= data_reg[i-1];
                ovf_reg[i]   <= ovf_reg[i-1];
            end
        end
    end

endmodule

// File: tb/tb_paramshift_pipe.sv
// Scoreboard bench for paramshift_pipe. Instance A: 6-bit result, 3-bit operand, 2 stages.
// Instance B: 6-bit result, 6-bit operand, 3 stages.
module tb_paramshift_pipe;

    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRL = 2'b01;
    localparam logic [1:0] SRA = 2'b10;
    localparam logic [1:0] ROL = 2'b11;

    typedef struct {
        logic [5:0] d;
        logic       s;
        logic [1:0] m;
        logic [7:0] n;
        logic [5:0] ed;
        logic       eo;
    } vec_t;

    typedef struct {
        logic [5:0] d;
        logic       o;
        int         due;
        int         id;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       a_in_valid = 1'b0, a_in_ready, a_in_signed = 1'b0;
    logic [2:0] a_in_data = '0;
    logic [1:0] a_in_mode = '0;
    logic [7:0] a_in_amt = '0;
    logic       a_out_valid, a_out_ready = 1'b1, a_out_ovf;
    logic [5:0] a_out_data;

    logic       b_in_valid = 1'b0, b_in_ready, b_in_signed = 1'b0;
    logic [5:0] b_in_data = '0;
    logic [1:0] b_in_mode = '0;
    logic [7:0] b_in_amt = '0;
    logic       b_out_valid, b_out_ready = 1'b1, b_out_ovf;
    logic [5:0] b_out_data;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int a_stall_cycles = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    logic       a_hold = 1'b0;
    logic [5:0] a_hold_d;
    logic       a_hold_o;
    vec_t va[11];
    vec_t vb[14];
    vec_t vr0, vr1, vpost;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    paramshift_pipe #(.WIDTH(6), .IN_WIDTH(3), .AMT_W(8), .STAGES(2)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_signed(a_in_signed), .in_mode(a_in_mode), .in_amt(a_in_amt),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_ovf(a_out_ovf)
    );

    paramshift_pipe #(.WIDTH(6), .IN_WIDTH(6), .AMT_W(8), .STAGES(3)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_signed(b_in_signed), .in_mode(b_in_mode), .in_amt(b_in_amt),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_ovf(b_out_ovf)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    task automatic send_a(input vec_t v, input int id, input bit track);
        int waited = 0;
        a_in_valid = 1'b1; a_in_data = v.d[2:0]; a_in_signed = v.s;
        a_in_mode = v.m; a_in_amt = v.n;
        @(negedge clk);
        while (!a_in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!a_in_ready) begin
            checks++; failures++;
            $display("FAIL a_accept_timeout id=%0d in_ready=%b required=1", id, a_in_ready);
        end else if (track) begin
            qa.push_back('{v.ed, v.eo, 0, id});
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
    endtask

    task automatic send_b(input vec_t v, input int id, input bit track);
        int waited = 0;
        b_in_valid = 1'b1; b_in_data = v.d; b_in_signed = v.s;
        b_in_mode = v.m; b_in_amt = v.n;
        @(negedge clk);
        while (!b_in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!b_in_ready) begin
            checks++; failures++;
            $display("FAIL b_accept_timeout id=%0d in_ready=%b required=1", id, b_in_ready);
        end else if (track) begin
            // Accepted at the coming edge; visible two edges after that one.
            qb.push_back('{v.ed, v.eo, cyc + 3, id});
        end
        @(posedge clk); #1;
        b_in_valid = 1'b0;
    endtask

    task automatic drain(input bit which_b);
        int waited = 0;
        while (((which_b ? qb.size() : qa.size()) != 0) && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        chk(which_b ? "b_drain_left" : "a_drain_left", which_b ? qb.size() : qa.size(), 0);
        @(posedge clk); #1;
    endtask

    // Monitor A: handshake rule, stability under stall, in-order results.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (a_in_ready !== (!a_out_valid || a_out_ready)) begin
                failures++;
                $display("FAIL a_in_ready got=%b required=%b", a_in_ready, (!a_out_valid || a_out_ready));
            end
            if (a_hold) begin
                checks++;
                if (a_out_valid !== 1'b1 || a_out_data !== a_hold_d || a_out_ovf !== a_hold_o) begin
                    failures++;
                    $display("FAIL a_stall_stable got v=%b d=%b o=%b required v=1 d=%b o=%b",
                             a_out_valid, a_out_data, a_out_ovf, a_hold_d, a_hold_o);
                end
            end
            if (a_out_valid === 1'b1 && a_out_ready) begin
                checks++;
                if (qa.size() == 0) begin
                    failures++;
                    $display("FAIL a_unexpected got d=%b o=%b required no output", a_out_data, a_out_ovf);
                end else begin
                    ea = qa.pop_front();
                    if (a_out_data !== ea.d || a_out_ovf !== ea.o) begin
                        failures++;
                        $display("FAIL a_result id=%0d got d=%b o=%b required d=%b o=%b",
                                 ea.id, a_out_data, a_out_ovf, ea.d, ea.o);
                    end
                end
            end
            if (!a_in_ready) a_stall_cycles++;
            a_hold   = a_out_valid && !a_out_ready;
            a_hold_d = a_out_data;
            a_hold_o = a_out_ovf;
        end else begin
            a_hold = 1'b0;
        end
    end

    // Monitor B: in-order results and exact latency.
    always @(negedge clk) begin
        if (rst_n && b_out_valid === 1'b1 && b_out_ready) begin
            checks++;
            if (qb.size() == 0) begin
                failures++;
                $display("FAIL b_unexpected got d=%b o=%b required no output", b_out_data, b_out_ovf);
            end else begin
                eb = qb.pop_front();
                if (b_out_data !== eb.d || b_out_ovf !== eb.o || cyc != eb.due) begin
                    failures++;
                    $display("FAIL b_result id=%0d got d=%b o=%b cyc=%0d required d=%b o=%b cyc=%0d",
                             eb.id, b_out_data, b_out_ovf, cyc, eb.d, eb.o, eb.due);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1);
    end

    initial begin
        // Instance A vectors: operand in d[2:0]; expected values hand-derived.
        va[0]  = '{6'b000110, 1'b1, SRA, 8'd1, 6'b111111, 1'b0};
        va[1]  = '{6'b000110, 1'b0, SRA, 8'd1, 6'b000011, 1'b0};
        va[2]  = '{6'b000100, 1'b0, SLL, 8'd1, 6'b001000, 1'b0};
        va[3]  = '{6'b000100, 1'b1, SLL, 8'd1, 6'b111000, 1'b0};
        va[4]  = '{6'b000100, 1'b0, SLL, 8'd6, 6'b000000, 1'b1};
        va[5]  = '{6'b000000, 1'b0, SLL, 8'd9, 6'b000000, 1'b0};
        va[6]  = '{6'b000011, 1'b0, SLL, 8'd4, 6'b110000, 1'b0};
        va[7]  = '{6'b000011, 1'b0, SLL, 8'd5, 6'b100000, 1'b1};
        va[8]  = '{6'b000101, 1'b1, SRL, 8'd2, 6'b001111, 1'b0};
        va[9]  = '{6'b000101, 1'b1, ROL, 8'd2, 6'b110111, 1'b0};
        va[10] = '{6'b000010, 1'b1, SLL, 8'd4, 6'b100000, 1'b1};
        // Instance B vectors.
        vb[0]  = '{6'b000110, 1'b0, ROL, 8'd7,   6'b001100, 1'b0};
        vb[1]  = '{6'b000110, 1'b0, SRL, 8'd63,  6'b000000, 1'b0};
        vb[2]  = '{6'b100000, 1'b1, SRA, 8'd40,  6'b111111, 1'b0};
        vb[3]  = '{6'b101101, 1'b0, ROL, 8'd6,   6'b101101, 1'b0};
        vb[4]  = '{6'b101101, 1'b0, ROL, 8'd11,  6'b110110, 1'b0};
        vb[5]  = '{6'b101101, 1'b1, SRA, 8'd2,   6'b111011, 1'b0};
        vb[6]  = '{6'b101101, 1'b0, SRA, 8'd2,   6'b001011, 1'b0};
        vb[7]  = '{6'b101101, 1'b1, SLL, 8'd1,   6'b011010, 1'b1};
        vb[8]  = '{6'b111111, 1'b1, SLL, 8'd5,   6'b100000, 1'b0};
        vb[9]  = '{6'b111111, 1'b0, SLL, 8'd5,   6'b100000, 1'b1};
        vb[10] = '{6'b000001, 1'b0, SLL, 8'd255, 6'b000000, 1'b1};
        vb[11] = '{6'b100000, 1'b0, SRA, 8'd40,  6'b000000, 1'b0};
        vb[12] = '{6'b100000, 1'b1, SRL, 8'd5,   6'b000001, 1'b0};
        vb[13] = '{6'b010011, 1'b0, ROL, 8'd255, 6'b011010, 1'b0};
        vr0    = '{6'b000011, 1'b0, SLL, 8'd1,   6'b000110, 1'b0};
        vr1    = '{6'b111111, 1'b1, SRA, 8'd3,   6'b111111, 1'b0};
        vpost  = '{6'b000001, 1'b0, SLL, 8'd2,   6'b000100, 1'b0};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("a_reset_out_valid", a_out_valid, 0);
        chk("a_reset_out_data",  a_out_data, 0);
        chk("a_reset_out_ovf",   a_out_ovf, 0);
        chk("a_reset_in_ready",  a_in_ready, 1);
        chk("b_reset_out_valid", b_out_valid, 0);
        chk("b_reset_out_data",  b_out_data, 0);
        chk("b_reset_out_ovf",   b_out_ovf, 0);
        chk("b_reset_in_ready",  b_in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Extension and SLL overflow directed vectors.
        for (int i = 0; i < 6; i++) send_a(va[i], i, 1'b1);
        drain(1'b0);

        // Backpressure: five back-to-back transactions, output stalled 4 cycles.
        a_stall_cycles = 0;
        fork
            begin
                for (int i = 6; i < 11; i++) send_a(va[i], i, 1'b1);
            end
            begin
                repeat (2) @(posedge clk);
                #1 a_out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 a_out_ready = 1'b1;
            end
        join
        drain(1'b0);
        chk("a_stall_seen", (a_stall_cycles > 0), 1);

        // Streaming with latency check on the 3-stage instance.
        for (int i = 0; i < 14; i++) send_b(vb[i], i, 1'b1);
        drain(1'b1);

        // Reset with two transactions in flight.
        send_b(vr0, 100, 1'b0);
        send_b(vr1, 101, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("b_midreset_out_valid", b_out_valid, 0);
        chk("b_midreset_out_data",  b_out_data, 0);
        chk("b_midreset_out_ovf",   b_out_ovf, 0);
        chk("b_midreset_in_ready",  b_in_ready, 1);
        repeat (8) @(negedge clk);
        @(posedge clk); #1;

        // Pipeline still works after the mid-operation reset.
        send_b(vpost, 200, 1'b1);
        drain(1'b1);

        chk("a_queue_empty", qa.size(), 0);
        chk("b_queue_empty", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
